// File: rtl/mem_wb_elastic_reg_pkg.sv
// Purpose : shared types and constants for the MEM->WB elastic pipeline register.
// Contents: payload widths, the MEM->WB payload struct, the occupancy state encoding
//           and the write-back value select helper.
package mem_wb_elastic_reg_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned CNT_W_DFLT = 16;
  localparam int unsigned ST_W       = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  // One MEM->WB entry as held in the main or skid register.
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     data_mem;
  } mem_wb_pl_t;

  // Value the register file would receive: load data for loads, ALU result otherwise.
  function automatic logic [DATA_W-1:0] wb_select(input mem_wb_pl_t pl);
    return pl.mem_r_en ? pl.data_mem : pl.alu_res;
  endfunction

endpackage

// File: rtl/mem_wb_elastic_reg_if.sv
// Purpose : MEM->WB handshake and payload bundle.
// Ports   : in_valid/in_ready + WB_en_in, MEM_r_en_in, dest_in, alu_res_in, data_mem_in (MEM side);
//           out_valid/out_ready + WB_en_out, MEM_r_en_out, dest_out, alu_res_out, data_mem_out,
//           wb_value, stall_cnt (WB side).
// Modports: slave = the pipeline register, master = its environment (MEM and WB stages).
interface mem_wb_elastic_reg_if #(
  parameter int unsigned CNT_W = mem_wb_elastic_reg_pkg::CNT_W_DFLT
);
  import mem_wb_elastic_reg_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  WB_en_in;
  logic                  MEM_r_en_in;
  logic [REG_ADDR_W-1:0] dest_in;
  logic [DATA_W-1:0]     alu_res_in;
  logic [DATA_W-1:0]     data_mem_in;

  logic                  out_valid;
  logic                  out_ready;
  logic                  WB_en_out;
  logic                  MEM_r_en_out;
  logic [REG_ADDR_W-1:0] dest_out;
  logic [DATA_W-1:0]     alu_res_out;
  logic [DATA_W-1:0]     data_mem_out;
  logic [DATA_W-1:0]     wb_value;
  logic [CNT_W-1:0]      stall_cnt;

  modport slave (
    input  in_valid, WB_en_in, MEM_r_en_in, dest_in, alu_res_in, data_mem_in, out_ready,
    output in_ready, out_valid, WB_en_out, MEM_r_en_out, dest_out, alu_res_out, data_mem_out,
           wb_value, stall_cnt
  );

  modport master (
    output in_valid, WB_en_in, MEM_r_en_in, dest_in, alu_res_in, data_mem_in, out_ready,
    input  in_ready, out_valid, WB_en_out, MEM_r_en_out, dest_out, alu_res_out, data_mem_out,
           wb_value, stall_cnt
  );

endinterface

// File: rtl/mem_wb_elastic_reg_sat_counter.sv
// Purpose : saturating up-counter with asynchronous active-low clear.
// Ports   : clk, rst_n (async clear), i_inc (count enable), o_cnt (registered count).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = &r_cnt;

  // Count enabled cycles, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// Purpose : MEM->WB pipeline register with a 2-entry skid buffer so in_ready is registered
//           while throughput stays at one entry per cycle. Adds synchronous flush, a
//           combinational write-back value tap and a saturating stall counter.
// Ports   : clk, rst_n (async, active-low), flush (sync kill of held entries),
//           bus (slave modport: MEM-side valid/ready/payload, WB-side valid/ready/payload,
//           wb_value, stall_cnt).
module mem_wb_elastic_reg
  import mem_wb_elastic_reg_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  mem_wb_elastic_reg_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  mem_wb_pl_t       r_main;
  mem_wb_pl_t       r_skid;
  mem_wb_pl_t       w_in_pl;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_ld_in;
  logic             w_main_ld_skid;
  logic             w_main_clr;
  logic             w_skid_ld;
  logic             w_skid_clr;
  logic             w_stall_inc;
  logic [CNT_W-1:0] w_stall_cnt;

  assign w_in_pl = '{wb_en:    bus.WB_en_in,
                     mem_r_en: bus.MEM_r_en_in,
                     dest:     bus.dest_in,
                     alu_res:  bus.alu_res_in,
                     data_mem: bus.data_mem_in};

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: occupancy tracking, flush wins over any transfer.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = ST_FULL;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_out_xfer) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Datapath controls: which register loads from where.
  always_comb begin
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_main_clr     = 1'b0;
    w_skid_ld      = 1'b0;
    w_skid_clr     = 1'b0;
    if (flush) begin
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: w_main_ld_in = w_in_xfer;
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) w_main_ld_in = 1'b1;
          else if (w_in_xfer)          w_skid_ld    = 1'b1;
          else if (w_out_xfer)         w_main_clr   = 1'b1;  // drained: outputs return to 0
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_main_ld_skid = 1'b1;
            w_skid_clr     = 1'b1;
          end
        end
        default: begin
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Handshake flags registered from the next state so neither side sees a comb path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Main (head) entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
    end else if (w_main_clr) begin
      r_main <= '0;
    end else if (w_main_ld_in) begin
      r_main <= w_in_pl;
    end else if (w_main_ld_skid) begin
      r_main <= r_skid;
    end
  end

  // Skid entry: catches the input accepted on the cycle WB stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= '0;
    end else if (w_skid_clr) begin
      r_skid <= '0;
    end else if (w_skid_ld) begin
      r_skid <= w_in_pl;
    end
  end

  assign w_stall_inc = r_out_valid & ~bus.out_ready & ~flush;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall_inc),
    .o_cnt (w_stall_cnt)
  );

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.WB_en_out    = r_main.wb_en & r_out_valid;
  assign bus.MEM_r_en_out = r_main.mem_r_en & r_out_valid;
  assign bus.dest_out     = r_main.dest;
  assign bus.alu_res_out  = r_main.alu_res;
  assign bus.data_mem_out = r_main.data_mem;
  assign bus.wb_value     = r_out_valid ? wb_select(r_main) : '0;
  assign bus.stall_cnt    = w_stall_cnt;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Bench for mem_wb_elastic_reg: directed stimulus, a queue-based reference model checked
// every cycle, and literal expectations at the interesting points of each scenario.
module tb_mem_wb_elastic_reg;
  import mem_wb_elastic_reg_pkg::*;

  localparam int unsigned TB_CNT_W = 4;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic flush;

  mem_wb_elastic_reg_if #(.CNT_W(TB_CNT_W)) bus ();

  mem_wb_elastic_reg #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  mem_wb_pl_t      mq[$];
  int              m_cnt = 0;
  mem_wb_pl_t      m_in;
  mem_wb_pl_t      h;
  logic [3:0]      seen[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries; ready means "not holding two".
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_in = '{wb_en: bus.WB_en_in, mem_r_en: bus.MEM_r_en_in, dest: bus.dest_in,
               alu_res: bus.alu_res_in, data_mem: bus.data_mem_in};
      if (mq.size() > 0 && !bus.out_ready && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (bus.in_valid && mq.size() < 2) begin
        if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
        mq.push_back(m_in);
      end else if (mq.size() > 0 && bus.out_ready) begin
        void'(mq.pop_front());
      end
    end
  end

  // Per-cycle compare against the model, plus a log of consumed destinations.
  always @(negedge clk) begin
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("in_ready",     64'(bus.in_ready),     64'(mq.size() < 2));
    chk("out_valid",    64'(bus.out_valid),    64'(mq.size() > 0));
    chk("WB_en_out",    64'(bus.WB_en_out),    64'(h.wb_en));
    chk("MEM_r_en_out", 64'(bus.MEM_r_en_out), 64'(h.mem_r_en));
    chk("dest_out",     64'(bus.dest_out),     64'(h.dest));
    chk("alu_res_out",  64'(bus.alu_res_out),  64'(h.alu_res));
    chk("data_mem_out", 64'(bus.data_mem_out), 64'(h.data_mem));
    chk("wb_value",     64'(bus.wb_value),     64'(h.mem_r_en ? h.data_mem : h.alu_res));
    chk("stall_cnt",    64'(bus.stall_cnt),    64'(m_cnt));
    if (rst_n && bus.out_valid && bus.out_ready && !flush) seen.push_back(bus.dest_out);
  end

  task automatic drive(input logic iv, input logic wb, input logic mr, input logic [3:0] d,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic ordy, input logic fl);
    bus.in_valid    = iv;
    bus.WB_en_in    = wb;
    bus.MEM_r_en_in = mr;
    bus.dest_in     = d;
    bus.alu_res_in  = alu;
    bus.data_mem_in = dm;
    bus.out_ready   = ordy;
    flush           = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 4'hF, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);

    // Reset with a valid input present.
    tick(); tick();
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_WB_en",     64'(bus.WB_en_out), 64'd0);
    chk("rst_dest",      64'(bus.dest_out),  64'd0);
    chk("rst_wb_value",  64'(bus.wb_value),  64'd0);
    chk("rst_stall",     64'(bus.stall_cnt), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick(); tick();
    chk("rel_no_entry", 64'(bus.out_valid), 64'd0);

    // Streaming: one entry per cycle, one-cycle latency.
    seen.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'(i % 2), 4'(i), 32'(i * 16), 32'(i * 256 + 1), 1'b1, 1'b0);
      tick();
      chk("stream_dest",  64'(bus.dest_out), 64'(i));
      chk("stream_ready", 64'(bus.in_ready), 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick(); tick();
    chk("stream_count", 64'(seen.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("stream_order", 64'(seen[i]), 64'(i + 1));

    // Backpressure: two entries held, stall counted, then drained in order.
    seen.delete();
    drive(1'b1, 1'b1, 1'b0, 4'd9,  32'h90, 32'h900, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 4'd10, 32'hA0, 32'hA00, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 4'd11, 32'hB0, 32'hB00, 1'b0, 1'b0); tick(); tick(); tick();
    chk("bp_stall",    64'(bus.stall_cnt), 64'd4);
    chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
    chk("bp_head",     64'(bus.dest_out),  64'd9);
    drive(1'b1, 1'b1, 1'b0, 4'd11, 32'hB0, 32'hB00, 1'b1, 1'b0); tick();
    chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
    chk("bp_head2",      64'(bus.dest_out), 64'd10);
    tick();
    chk("bp_head3", 64'(bus.dest_out), 64'd11);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    chk("bp_empty",  64'(bus.out_valid), 64'd0);
    chk("bp_count",  64'(seen.size()),   64'd3);
    for (int i = 0; i < 3; i++) chk("bp_order", 64'(seen[i]), 64'(9 + i));

    // Flush while full with a same-cycle input.
    seen.delete();
    drive(1'b1, 1'b1, 1'b0, 4'd12, 32'hC0, 32'hC00, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 4'd13, 32'hD0, 32'hD00, 1'b0, 1'b0); tick();
    chk("fl_full", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 4'd14, 32'hE0, 32'hE00, 1'b0, 1'b1); tick();
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_WB_en",     64'(bus.WB_en_out), 64'd0);
    chk("fl_in_ready",  64'(bus.in_ready),  64'd1);
    chk("fl_stall",     64'(bus.stall_cnt), 64'd5);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0); tick(); tick();
    chk("fl_nothing_out", 64'(seen.size()), 64'd0);

    // Forwarding tap: load selects memory data, otherwise ALU result.
    drive(1'b1, 1'b1, 1'b1, 4'd3, 32'h10, 32'hCAFE, 1'b0, 1'b0); tick();
    chk("fwd_load",     64'(bus.wb_value),     64'h0000CAFE);
    chk("fwd_load_mr",  64'(bus.MEM_r_en_out), 64'd1);
    drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h10, 32'hCAFE, 1'b1, 1'b0); tick();
    chk("fwd_alu",      64'(bus.wb_value),     64'h10);
    chk("fwd_alu_mr",   64'(bus.MEM_r_en_out), 64'd0);
    chk("fwd_alu_dest", 64'(bus.dest_out),     64'd4);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0); tick();

    // Saturation, then asynchronous reset mid-stall.
    drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h55, 32'h66, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (20) tick();
    chk("sat_stall", 64'(bus.stall_cnt), 64'd15);
    chk("sat_head",  64'(bus.dest_out),  64'd5);
    rst_n = 1'b0;
    #1;
    chk("arst_stall",     64'(bus.stall_cnt), 64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("arst_dest",      64'(bus.dest_out),  64'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_empty", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
